// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and default widths for the CPU/DMA memory arbiter.
package memory_arbiter_pkg;
    localparam int ADDR_W = 128;
    localparam int DATA_W = 128;
    typedef enum logic {CPU_PRI, DMA_BURST} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
endpackage

// File: rtl/arb_counter.sv
// arb_counter: saturating up-counter with synchronous clear.
module arb_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: CPU-priority arbiter for one synchronous memory port, with
// starvation-triggered DMA bursts and tagged routing of read returns.
module memory_arbiter #(
    parameter int ADDR_W     = memory_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = memory_arbiter_pkg::DATA_W,
    parameter int STARVE_MAX = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_vf,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic              mem_vf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              burst_active
);
    import memory_arbiter_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [SW-1:0]     starve_cnt;
    logic [BW-1:0]     burst_cnt;
    logic              starve_inc, starve_clr, burst_inc, burst_clr;

    arb_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
        .clk(clk), .rst(rst), .inc(starve_inc), .clr(starve_clr), .cnt(starve_cnt)
    );

    arb_counter #(.MAX(BURST_LEN), .W(BW)) u_burst (
        .clk(clk), .rst(rst), .inc(burst_inc), .clr(burst_clr), .cnt(burst_cnt)
    );

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        state_d = state_q;
        // no grant may reach memory while reset is held
        if (rst) begin
            if (state_q == CPU_PRI) begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req & ~cpu_req;
            end else begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req & ~dma_req;
            end
        end
        starve_inc = (state_q == CPU_PRI) && dma_req && !dma_gnt;
        starve_clr = dma_gnt || (state_q == DMA_BURST);
        burst_inc  = (state_q == DMA_BURST) && dma_gnt;
        burst_clr  = (state_q == CPU_PRI);
        if (state_q == CPU_PRI)
            state_d = (starve_inc && starve_cnt == SW'(STARVE_MAX - 1)) ? DMA_BURST : CPU_PRI;
        else
            state_d = (!dma_req || burst_cnt == BW'(BURST_LEN - 1)) ? CPU_PRI : DMA_BURST;
        owner_d = (cpu_gnt && !cpu_we) ? OWN_CPU : dma_gnt ? OWN_DMA : OWN_NONE;
        addr_d  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : addr_q;
        // hold the last returned word between reads
        rdata_d = (owner_q != OWN_NONE) ? mem_rd : rdata_q;
    end

    assign mem_addr     = addr_d;
    assign mem_we       = cpu_we & cpu_gnt;
    assign mem_vf       = cpu_vf & cpu_gnt;
    assign mem_wd       = cpu_wd;
    assign cpu_rvalid   = (owner_q == OWN_CPU);
    assign dma_rvalid   = (owner_q == OWN_DMA);
    assign rdata        = rdata_d;
    assign burst_active = (state_q == DMA_BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CPU_PRI;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end
endmodule
